// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: opcodes, funct codes, the encoder's
// symbolic operation enum, the word width and the encoder FSM states.
package mips_pkg;

  localparam int WORD_W = 32;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // R-type function codes (instruction bits 5:0)
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Symbolic operation selector presented on the field input
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8,
    OP_J    = 4'd9
  } op_e;

  // Encoder sequencing states
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_e;

  // R-type word assembly: shamt is always zero for the supported ops
  function automatic logic [WORD_W-1:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                                   input logic [4:0] rd, input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational fields-to-word packer with a legal flag.
// Optional feature macro: IENC_BRANCH_REL_EN (beq offset computed from
// IN_TARGET relative to pc+4 instead of taking the immediate verbatim).
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic [31:0]       target_i,
  input  logic [31:0]       pc_i,
  output logic [WORD_W-1:0] word_o,
  output logic              legal_o
);

`ifdef IENC_BRANCH_REL_EN
  logic [31:0] br_diff_s;
  logic        br_ok_s;

  // Byte distance from the delay-slot address; the word offset fits in
  // 16 signed bits exactly when bits 31:17 are a sign extension of bit 17.
  assign br_diff_s = target_i - (pc_i + 32'd4);
  assign br_ok_s   = (target_i[1:0] == 2'b00) && (br_diff_s[31:17] == {15{br_diff_s[17]}});
`else
  logic unused_s;
  assign unused_s = ^{pc_i, target_i[31:28], target_i[1:0]};
`endif

  // Select the instruction format for the requested operation
  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (op_e'(op_i))
      OP_ADD:  word_o = pack_rtype(rs_i, rt_i, rd_i, FN_ADD);
      OP_SUB:  word_o = pack_rtype(rs_i, rt_i, rd_i, FN_SUB);
      OP_AND:  word_o = pack_rtype(rs_i, rt_i, rd_i, FN_AND);
      OP_OR:   word_o = pack_rtype(rs_i, rt_i, rd_i, FN_OR);
      OP_SLT:  word_o = pack_rtype(rs_i, rt_i, rd_i, FN_SLT);
      OP_ADDI: word_o = {OPC_ADDI, rs_i, rt_i, imm_i};
      OP_LW:   word_o = {OPC_LW, rs_i, rt_i, imm_i};
      OP_SW:   word_o = {OPC_SW, rs_i, rt_i, imm_i};
      OP_BEQ: begin
`ifdef IENC_BRANCH_REL_EN
        word_o  = {OPC_BEQ, rs_i, rt_i, br_diff_s[17:2]};
        legal_o = br_ok_s;
`else
        word_o  = {OPC_BEQ, rs_i, rt_i, imm_i};
`endif
      end
      OP_J:    word_o = {OPC_J, target_i[27:2]};
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS field sets and writes the words sequentially into
// instruction memory via a WE/READY write port. All outputs are registered.
// Optional feature macro: IENC_BRANCH_REL_EN (handled in mips_instr_pack).
module mips_instr_encoder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  in_op_i,
  input  logic [4:0]  in_rs_i,
  input  logic [4:0]  in_rt_i,
  input  logic [4:0]  in_rd_i,
  input  logic [15:0] in_imm_i,
  input  logic [31:0] in_target_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  output logic [15:0] count_o,
  output logic        full_o,
  output logic        err_o
);

  localparam logic [15:0] DEPTH_C = 16'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [15:0] count_q, count_d;
  logic        full_q, full_d;
  logic        err_q, err_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] word_s;
  logic        legal_s;

  mips_instr_pack u_pack (
    .op_i     (in_op_i),
    .rs_i     (in_rs_i),
    .rt_i     (in_rt_i),
    .rd_i     (in_rd_i),
    .imm_i    (in_imm_i),
    .target_i (in_target_i),
    .pc_i     (ptr_q),
    .word_o   (word_s),
    .legal_o  (legal_s)
  );

  // Next-state and next-output logic; START overrides every other event
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    full_d      = full_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start_i) begin
      state_d    = S_IDLE;
      ptr_d      = BASE_ADDR;
      count_d    = 16'd0;
      full_d     = 1'b0;
      err_d      = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = BASE_ADDR;
      in_ready_d = (DEPTH_C != 16'd0);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i && in_ready_q) begin
            if (legal_s) begin
              state_d     = S_WRITE;
              mem_we_d    = 1'b1;
              mem_addr_d  = ptr_q;
              mem_wdata_d = word_s;
              in_ready_d  = 1'b0;
            end else begin
              err_d      = 1'b1;
              in_ready_d = !full_q;
            end
          end else begin
            in_ready_d = !full_q;
          end
        end
        S_WRITE: begin
          if (mem_ready_i) begin
            state_d    = S_IDLE;
            mem_we_d   = 1'b0;
            ptr_d      = ptr_q + 32'd4;
            count_d    = count_q + 16'd1;
            full_d     = ((count_q + 16'd1) == DEPTH_C);
            in_ready_d = ((count_q + 16'd1) != DEPTH_C);
          end else begin
            in_ready_d = 1'b0;
          end
        end
        default: begin
          state_d    = S_IDLE;
          mem_we_d   = 1'b0;
          in_ready_d = 1'b0;
        end
      endcase
    end
  end

  // State, pointer, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= BASE_ADDR;
      count_q     <= 16'd0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed steps followed by
// randomized field sets checked against an arithmetic reference model.
module tb_mips_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          DEP  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [15:0] in_imm = 16'd0;
  logic [31:0] in_target = 32'd0;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [15:0] count;
  logic        full, err;

  int total = 0;
  int bad   = 0;

  // model state
  int unsigned m_ptr   = 0;
  int          m_count = 0;
  bit          m_full  = 0;
  bit          m_err   = 0;
  logic [31:0] last_wd;

  mips_instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_rs_i(in_rs), .in_rt_i(in_rt), .in_rd_i(in_rd),
    .in_imm_i(in_imm), .in_target_i(in_target),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .count_o(count), .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the instruction-format rules, by plain arithmetic
  function automatic logic [31:0] model_word(input int op, input int unsigned rs, input int unsigned rt,
                                             input int unsigned rd, input int unsigned imm,
                                             input int unsigned tgt, input int unsigned pc, output bit ok);
    longint unsigned w;
    longint          d;
    int              fn;
    ok = 1;
    w  = 0;
    fn = 0;
    case (op)
      0: fn = 32;
      1: fn = 34;
      2: fn = 36;
      3: fn = 37;
      4: fn = 42;
      default: fn = 0;
    endcase
    if (op <= 4)       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + fn;
    else if (op == 5)  w = 8 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    else if (op == 6)  w = 35 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    else if (op == 7)  w = 43 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    else if (op == 8) begin
`ifdef IENC_BRANCH_REL_EN
      d  = longint'(tgt) - longint'(pc) - 4;
      ok = (tgt % 4 == 0) && (d / 4 >= -32768) && (d / 4 <= 32767);
      w  = 4 * 2**26 + rs * 2**21 + rt * 2**16 + ((d / 4) & 65535);
`else
      w  = 4 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
`endif
    end
    else if (op == 9)  w = 2 * 2**26 + (tgt / 4) % 2**26;
    else ok = 0;
    return w[31:0];
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_ptr = BASE; m_count = 0; m_full = 0; m_err = 0;
    chk("start_we", mem_we, 0);
    chk("start_count", count, 0);
    chk("start_full", full, 0);
    chk("start_err", err, 0);
    chk("start_ready", in_ready, 1);
  endtask

  // Offer one field set, then stall the memory 'stall' cycles before accepting
  task automatic do_op(input int op, input int unsigned rs, input int unsigned rt, input int unsigned rd,
                       input int unsigned imm, input int unsigned tgt, input int stall);
    logic [31:0] ew;
    bit ok;
    ew = model_word(op, rs, rt, rd, imm, tgt, m_ptr, ok);
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_target = tgt;
    in_valid = 1'b1;
    chk("ready_pre", in_ready, m_full ? 0 : 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (m_full) begin
      chk("full_no_we", mem_we, 0);
      chk("full_count", count, m_count);
      chk("full_ready", in_ready, 0);
    end else if (!ok) begin
      m_err = 1;
      chk("ill_no_we", mem_we, 0);
      chk("ill_err", err, 1);
      chk("ill_count", count, m_count);
      chk("ill_ready", in_ready, 1);
    end else begin
      for (int i = 0; i <= stall; i++) begin
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, m_ptr);
        chk("wr_data", mem_wdata, ew);
        chk("wr_ready", in_ready, 0);
        last_wd = mem_wdata;
        if (i == stall) mem_ready = 1'b1;
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      m_ptr += 4;
      m_count++;
      m_full = (m_count == DEP);
      chk("done_we", mem_we, 0);
      chk("done_count", count, m_count);
      chk("done_full", full, m_full);
      chk("done_ready", in_ready, m_full ? 0 : 1);
      chk("done_err", err, m_err);
    end
  endtask

  initial begin
    int unsigned op;
    // reset state
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_rise", in_ready, 1);

    // add rd=3 rs=1 rt=2
    do_op(0, 1, 2, 3, 0, 0, 0);
    chk("add_word", last_wd, 32'h0022_1820);

    // addi / lw / sw sequence, lw stalled 3 cycles
    do_start();
    do_op(5, 0, 1, 0, 16'hFFFF, 0, 0);
    chk("addi_word", last_wd, 32'h2001_FFFF);
    do_op(6, 1, 2, 0, 4, 0, 3);
    chk("lw_word", last_wd, 32'h8C22_0004);
    do_op(7, 1, 2, 0, 8, 0, 0);
    chk("sw_word", last_wd, 32'hAC22_0008);

    // illegal op then j; ERR sticky
    do_start();
    do_op(15, 1, 2, 3, 0, 0, 0);
    do_op(9, 0, 0, 0, 0, 32'h40, 0);
    chk("j_word", last_wd, 32'h0800_0010);
    chk("err_sticky", err, 1);

    // beq at ptr 0
    do_start();
`ifdef IENC_BRANCH_REL_EN
    do_op(8, 1, 2, 0, 0, 32'h10, 0);
    chk("beq_rel_word", last_wd, 32'h1022_0003);
    do_start();
    do_op(8, 1, 2, 0, 0, 32'h2, 0);
    chk("beq_mis_err", err, 1);
`else
    do_op(8, 1, 2, 0, 3, 32'h2, 0);
    chk("beq_imm_word", last_wd, 32'h1022_0003);
`endif

    // fill to DEPTH, then an extra op must be refused
    do_start();
    for (int i = 0; i < DEP; i++) do_op(1, i, i + 1, i + 2, 0, 0, i % 2);
    chk("full_flag", full, 1);
    do_op(2, 3, 4, 5, 0, 0, 0);
    do_start();
    do_op(3, 7, 8, 9, 0, 0, 0);
    chk("after_full_word", last_wd, 32'h00E8_4825);

    // START abandons a pending write
    in_op = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pend_we", mem_we, 1);
    do_start();

    // asynchronous reset mid-write drops MEM_WE immediately
    in_op = 4'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pend2_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("async_we", mem_we, 0);
    chk("async_ready", in_ready, 0);
    chk("async_addr", mem_addr, BASE);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    m_ptr = BASE; m_count = 0; m_full = 0; m_err = 0;
    chk("rerst_ready", in_ready, 1);

    // randomized field sets
    for (int n = 0; n < 80; n++) begin
      if (m_full || $urandom_range(0, 11) == 0) do_start();
      op = $urandom_range(0, 11);
      do_op(int'(op), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFF), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
